tqvp_gera_gray_sequencer: RTL and testbench
===========================================

# tqvp_gera_gray_sequencer

TinyQV peripheral that autonomously steps an 8-bit binary counter and presents its Gray-coded value on the output PMOD at a programmable rate. It sequences the Gray datapath without CPU involvement: programmable start/limit, direction, wrap-or-stop, single-step and a sticky status register. It also provides a combinational Gray-to-binary read of the input PMOD for closed-loop checking. It sits in the TinyQV user-peripheral slot with the standard peripheral port set.

## Interface
- No parameters.
- clk  in  1  TinyQV project clock (64 MHz nominal).
- rst_n  in  1  reset, synchronous, active-low.
- ui_in  in  8  input PMOD, already synchronised; used only for the DECODE read.
- uo_out  out  8  gray(COUNT) when CTRL.oe=1, else 8'h00.
- address  in  4  register select.
- data_write  in  1  one-cycle write strobe.
- data_in  in  8  write data, valid with data_write.
- data_out  out  8  combinational read of register at address.

## Operation
- Register map (R/W unless noted):
  - 0x0 CTRL: [0] run, [1] dir (0 up, 1 down), [2] wrap, [3] oe, [4] step (W1 pulse, reads 0), [5] clear (W1 pulse, reads 0).
  - 0x1 DIV_LO, 0x2 DIV_HI: 16-bit prescaler DIV; step period = DIV+1 cycles.
  - 0x3 START, 0x4 LIMIT: 8-bit.
  - 0x5 COUNT (RO, binary), 0x6 GRAY (RO, COUNT ^ (COUNT>>1)).
  - 0x7 STATUS: [0] busy (RO, =RUN state), [1] done, [2] wrapped; bits 1–2 are sticky and write-1-to-clear.
  - 0x8 DECODE (RO): Gray-to-binary of ui_in, b[7]=g[7], b[i]=g[i]^b[i+1].
  - 0x9–0xF: read 0, writes ignored.
- Reset: CTRL=0, DIV=0, START=0, LIMIT=8'hFF, COUNT=0, prescaler=0, done=wrapped=0, state IDLE. Therefore uo_out=0 and data_out is whatever is selected (all registers 0 except LIMIT=FF).
- FSM, two states:
  - IDLE → RUN on a CTRL write with run=1. The prescaler is loaded with DIV; COUNT is unchanged.
  - RUN → IDLE on a CTRL write with run=0 (COUNT holds), or on a terminal step with wrap=0.
- Step rule, applied on a prescaler tick in RUN or on a step pulse in IDLE:
  - COUNT==LIMIT and wrap=1: COUNT←START, wrapped←1.
  - COUNT==LIMIT and wrap=0: COUNT unchanged, done←1, CTRL.run←0, state→IDLE.
  - Otherwise: COUNT←COUNT+1 (dir=0) or COUNT−1 (dir=1), modulo 256. There is no implicit wrap at FF/00 unless LIMIT is set there.
- Prescaler in RUN: decrements each cycle. At 0 it ticks, executes one step, and reloads with DIV.
- step pulse while in RUN is ignored.
- clear pulse: COUNT←START, prescaler←DIV, done←0, wrapped←0. State and other CTRL bits are taken from the same write.
- Same-cycle priority: clear > step/tick. A CTRL write with clear=1 and step=1 performs only the clear.
- A tick and a STATUS W1C in the same cycle: the set wins.
- Writes to DIV, START and LIMIT in RUN take effect at the next reload, wrap or compare respectively. The LIMIT compare uses the current register value.

## Timing
- Write at edge n: register value visible at edge n+1. uo_out, GRAY and COUNT are combinational from the COUNT flop.
- Run started by a write at edge n: first step at edge n+DIV+1, then every DIV+1 cycles. DIV=0 steps every cycle.
- step pulse in IDLE, written at edge n: COUNT updates at edge n+1.
- Terminal stop: done, run=0 and busy=0 all become visible in the same cycle as the terminal tick's edge.
- DECODE and data_out: zero-latency combinational paths.
- Reset mid-run: all state returns to reset values at the next edge, regardless of prescaler value or pending pulses.

## Test plan
- Reset, then read all addresses → 0 except LIMIT=FF; uo_out=00.
- START=0, LIMIT=7, DIV=2, CTRL=0x0D (run, wrap, oe) → uo_out steps 00,01,03,02,06,07,05,04 every 3 cycles, then 00 with STATUS.wrapped=1.
- CTRL dir=1, wrap=0, START=5, LIMIT=2, clear then run → COUNT 5,4,3,2 then stop; STATUS=0x02, CTRL.run=0, COUNT holds 2.
- IDLE single-step: three step writes from COUNT=FE, LIMIT=FF, wrap=0 → COUNT FF, then FF with done=1, then unchanged.
- CTRL write with clear=1, step=1 mid-run at COUNT=40, START=10 → COUNT=10, stickies 0, no step in that cycle. Write STATUS=0x06 → stickies cleared.
- ui_in sweep of all 256 Gray codes → DECODE equals the binary index; rst_n low during RUN → COUNT=0, busy=0 next cycle.

Source files
------------

// File: rtl/tqvp_gera_gray_sequencer_if.sv
// TinyQV peripheral register bus: address/strobe/data from the CPU side, combinational read data back.
interface tqvp_gera_gray_sequencer_if;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;

    modport master (
        output address,
        output data_write,
        output data_in,
        input  data_out
    );

    modport slave (
        input  address,
        input  data_write,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/tqvp_gera_gray_sequencer.sv
// Autonomous 8-bit Gray-code sequencer with programmable rate, start/limit, direction,
// wrap-or-stop and single-step, plus a Gray-to-binary decode of the input PMOD.
module tqvp_gera_gray_sequencer (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [7:0]                     ui_in,
    output logic [7:0]                     uo_out,
    tqvp_gera_gray_sequencer_if.slave      bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [7:0] bin_to_gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [7:0] gray_to_bin(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    state_t      r_state;
    logic        r_run;
    logic        r_dir;
    logic        r_wrap;
    logic        r_oe;
    logic [15:0] r_div;
    logic [15:0] r_presc;
    logic [7:0]  r_start;
    logic [7:0]  r_limit;
    logic [7:0]  r_count;
    logic        r_done;
    logic        r_wrapped;

    logic        w_ctrl_wr;
    logic        w_clear;
    logic        w_tick;
    logic        w_step_pulse;
    logic        w_do_step;
    logic        w_dir_eff;
    logic        w_wrap_eff;
    logic        w_at_limit;
    logic [7:0]  w_step_val;
    logic        w_busy;

    // Step qualification; a CTRL write in the same cycle supplies the dir/wrap it carries.
    always_comb begin
        w_ctrl_wr    = bus.data_write && (bus.address == 4'h0);
        w_clear      = w_ctrl_wr && bus.data_in[5];
        w_busy       = (r_state == ST_RUN);
        w_tick       = w_busy && (r_presc == 16'h0000);
        w_step_pulse = w_ctrl_wr && bus.data_in[4] && (r_state == ST_IDLE);
        w_do_step    = (w_tick || w_step_pulse) && !w_clear;
        if (w_ctrl_wr) begin
            w_dir_eff  = bus.data_in[1];
            w_wrap_eff = bus.data_in[2];
        end else begin
            w_dir_eff  = r_dir;
            w_wrap_eff = r_wrap;
        end
        w_at_limit = (r_count == r_limit);
        if (w_dir_eff) begin
            w_step_val = r_count - 8'd1;
        end else begin
            w_step_val = r_count + 8'd1;
        end
    end

    // Register file, prescaler, stepping datapath and the IDLE/RUN state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_run     <= 1'b0;
            r_dir     <= 1'b0;
            r_wrap    <= 1'b0;
            r_oe      <= 1'b0;
            r_div     <= 16'h0000;
            r_presc   <= 16'h0000;
            r_start   <= 8'h00;
            r_limit   <= 8'hFF;
            r_count   <= 8'h00;
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            if (bus.data_write) begin
                case (bus.address)
                    4'h0: begin
                        r_run  <= bus.data_in[0];
                        r_dir  <= bus.data_in[1];
                        r_wrap <= bus.data_in[2];
                        r_oe   <= bus.data_in[3];
                    end
                    4'h1: r_div[7:0]  <= bus.data_in;
                    4'h2: r_div[15:8] <= bus.data_in;
                    4'h3: r_start     <= bus.data_in;
                    4'h4: r_limit     <= bus.data_in;
                    4'h7: begin
                        if (bus.data_in[1]) r_done    <= 1'b0;
                        if (bus.data_in[2]) r_wrapped <= 1'b0;
                    end
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_ctrl_wr && bus.data_in[0]) begin
                        r_state <= ST_RUN;
                        r_presc <= r_div;
                    end
                end
                ST_RUN: begin
                    if (w_ctrl_wr && !bus.data_in[0]) begin
                        r_state <= ST_IDLE;
                    end
                    if (r_presc == 16'h0000) begin
                        r_presc <= r_div;
                    end else begin
                        r_presc <= r_presc - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Later assignments win: clear beats a step, and sticky sets beat the W1C above.
            if (w_clear) begin
                r_count   <= r_start;
                r_presc   <= r_div;
                r_done    <= 1'b0;
                r_wrapped <= 1'b0;
            end else if (w_do_step) begin
                if (w_at_limit && w_wrap_eff) begin
                    r_count   <= r_start;
                    r_wrapped <= 1'b1;
                end else if (w_at_limit) begin
                    r_done  <= 1'b1;
                    r_run   <= 1'b0;
                    r_state <= ST_IDLE;
                end else begin
                    r_count <= w_step_val;
                end
            end
        end
    end

    // Combinational register read port.
    always_comb begin
        case (bus.address)
            4'h0:    bus.data_out = {4'b0000, r_oe, r_wrap, r_dir, r_run};
            4'h1:    bus.data_out = r_div[7:0];
            4'h2:    bus.data_out = r_div[15:8];
            4'h3:    bus.data_out = r_start;
            4'h4:    bus.data_out = r_limit;
            4'h5:    bus.data_out = r_count;
            4'h6:    bus.data_out = bin_to_gray(r_count);
            4'h7:    bus.data_out = {5'b00000, r_wrapped, r_done, w_busy};
            4'h8:    bus.data_out = gray_to_bin(ui_in);
            default: bus.data_out = 8'h00;
        endcase
    end

    assign uo_out = r_oe ? bin_to_gray(r_count) : 8'h00;

endmodule

// File: tb/tb_tqvp_gera_gray_sequencer.sv
// Scoreboard bench for the Gray sequencer: expected values are queued with the stimulus
// and popped when the DUT output they describe becomes observable.
module tb_tqvp_gera_gray_sequencer;

    logic       clk;
    logic       rst_n;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    int         total;
    int         bad;
    logic [7:0] sb_q[$];

    tqvp_gera_gray_sequencer_if bus();

    tqvp_gera_gray_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gray(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    // Write lands on the next posedge; returns 1ns after it.
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.data_in    = d;
        bus.data_write = 1'b1;
        @(posedge clk);
        #1;
        bus.data_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        @(negedge clk);
        bus.address = a;
        #1;
        v = bus.data_out;
    endtask

    task automatic test_reset;
        logic [7:0] v;
        logic [7:0] e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) sb_q.push_back((a == 4) ? 8'hFF : 8'h00);
        for (int a = 0; a < 16; a++) begin
            rd(a[3:0], v);
            e = sb_q.pop_front();
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL reset_read addr=%0h got=%h exp=%h", a, v, e);
            end
        end
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL reset_uo_out got=%h exp=00", uo_out);
        end
    endtask

    task automatic test_wrap_up;
        logic [7:0] v;
        logic [7:0] e;
        logic [7:0] seq [0:8];
        seq = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h07, 8'h05, 8'h04, 8'h00};
        wr(4'h3, 8'h00);
        wr(4'h4, 8'h07);
        wr(4'h1, 8'h02);
        for (int i = 0; i < 9; i++) sb_q.push_back(seq[i]);
        wr(4'h0, 8'h0D);
        for (int i = 0; i < 9; i++) begin
            if (i != 0) begin
                repeat (3) @(posedge clk);
                #1;
            end
            e = sb_q.pop_front();
            total++;
            if (uo_out !== e) begin
                bad++;
                $display("FAIL wrap_up_step%0d uo_out got=%h exp=%h", i, uo_out, e);
            end
        end
        rd(4'h7, v);
        total++;
        if (v !== 8'h05) begin
            bad++;
            $display("FAIL wrap_status got=%h exp=05", v);
        end
        wr(4'h0, 8'h00);
        rd(4'h7, v);
        total++;
        if (v !== 8'h04) begin
            bad++;
            $display("FAIL wrap_stop_status got=%h exp=04", v);
        end
    endtask

    task automatic test_down_stop;
        logic [7:0] v;
        logic [7:0] e;
        wr(4'h1, 8'h00);
        wr(4'h3, 8'h05);
        wr(4'h4, 8'h02);
        wr(4'h7, 8'h06);
        wr(4'h0, 8'h2A);
        sb_q.push_back(8'h05);
        sb_q.push_back(8'h04);
        sb_q.push_back(8'h03);
        sb_q.push_back(8'h02);
        sb_q.push_back(8'h02);
        wr(4'h0, 8'h0B);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) begin
                @(posedge clk);
                #1;
            end
            e = sb_q.pop_front();
            total++;
            if (uo_out !== gray(e)) begin
                bad++;
                $display("FAIL down_step%0d uo_out got=%h exp=%h", i, uo_out, gray(e));
            end
        end
        rd(4'h7, v);
        total++;
        if (v !== 8'h02) begin
            bad++;
            $display("FAIL down_status got=%h exp=02", v);
        end
        rd(4'h0, v);
        total++;
        if (v !== 8'h0A) begin
            bad++;
            $display("FAIL down_ctrl got=%h exp=0A", v);
        end
        rd(4'h5, v);
        total++;
        if (v !== 8'h02) begin
            bad++;
            $display("FAIL down_count got=%h exp=02", v);
        end
    endtask

    task automatic test_single_step;
        logic [7:0] v;
        logic [7:0] e;
        logic [7:0] st_exp [0:2];
        st_exp = '{8'h00, 8'h02, 8'h02};
        wr(4'h3, 8'hFE);
        wr(4'h4, 8'hFF);
        wr(4'h7, 8'h06);
        wr(4'h0, 8'h28);
        rd(4'h5, v);
        total++;
        if (v !== 8'hFE) begin
            bad++;
            $display("FAIL step_preload got=%h exp=FE", v);
        end
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(8'hFF);
            wr(4'h0, 8'h18);
            rd(4'h5, v);
            e = sb_q.pop_front();
            total++;
            if (v !== e) begin
                bad++;
                $display("FAIL step%0d_count got=%h exp=%h", i, v, e);
            end
            rd(4'h7, v);
            total++;
            if (v !== st_exp[i]) begin
                bad++;
                $display("FAIL step%0d_status got=%h exp=%h", i, v, st_exp[i]);
            end
        end
        rd(4'h0, v);
        total++;
        if (v !== 8'h08) begin
            bad++;
            $display("FAIL step_ctrl_readback got=%h exp=08", v);
        end
    endtask

    task automatic test_clear_priority;
        logic [7:0] v;
        wr(4'h3, 8'h40);
        wr(4'h4, 8'h40);
        wr(4'h0, 8'h28);
        wr(4'h0, 8'h1C);
        wr(4'h4, 8'hFF);
        wr(4'h3, 8'h10);
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h10);
        wr(4'h0, 8'h0D);
        rd(4'h5, v);
        total++;
        if (v !== 8'h40) begin
            bad++;
            $display("FAIL clr_pre_count got=%h exp=40", v);
        end
        rd(4'h7, v);
        total++;
        if (v !== 8'h05) begin
            bad++;
            $display("FAIL clr_pre_status got=%h exp=05", v);
        end
        wr(4'h0, 8'h3D);
        rd(4'h5, v);
        total++;
        if (v !== 8'h10) begin
            bad++;
            $display("FAIL clr_count got=%h exp=10", v);
        end
        rd(4'h7, v);
        total++;
        if (v !== 8'h01) begin
            bad++;
            $display("FAIL clr_status got=%h exp=01", v);
        end
        rd(4'h0, v);
        total++;
        if (v !== 8'h0D) begin
            bad++;
            $display("FAIL clr_ctrl got=%h exp=0D", v);
        end
        wr(4'h0, 8'h0C);
        wr(4'h4, 8'h10);
        wr(4'h0, 8'h1C);
        rd(4'h7, v);
        total++;
        if (v !== 8'h04) begin
            bad++;
            $display("FAIL w1c_pre_status got=%h exp=04", v);
        end
        wr(4'h7, 8'h06);
        rd(4'h7, v);
        total++;
        if (v !== 8'h00) begin
            bad++;
            $display("FAIL w1c_status got=%h exp=00", v);
        end
    endtask

    task automatic test_decode;
        logic [7:0] b;
        logic [7:0] e;
        @(negedge clk);
        bus.address = 4'h8;
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            ui_in = gray(b);
            sb_q.push_back(b);
            #1;
            e = sb_q.pop_front();
            total++;
            if (bus.data_out !== e) begin
                bad++;
                $display("FAIL decode gray=%h got=%h exp=%h", ui_in, bus.data_out, e);
            end
        end
        ui_in = 8'h00;
    endtask

    task automatic test_reset_midrun;
        wr(4'h2, 8'h00);
        wr(4'h1, 8'h00);
        wr(4'h3, 8'h00);
        wr(4'h4, 8'hFF);
        wr(4'h0, 8'h0D);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        bus.address = 4'h5;
        @(posedge clk);
        #1;
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_count got=%h exp=00", bus.data_out);
        end
        total++;
        if (uo_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_uo_out got=%h exp=00", uo_out);
        end
        bus.address = 4'h7;
        #1;
        total++;
        if (bus.data_out !== 8'h00) begin
            bad++;
            $display("FAIL rst_mid_status got=%h exp=00", bus.data_out);
        end
        bus.address = 4'h4;
        #1;
        total++;
        if (bus.data_out !== 8'hFF) begin
            bad++;
            $display("FAIL rst_mid_limit got=%h exp=FF", bus.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        ui_in          = 8'h00;
        bus.address    = 4'h0;
        bus.data_in    = 8'h00;
        bus.data_write = 1'b0;
        test_reset();
        test_wrap_up();
        test_down_stop();
        test_single_step();
        test_clear_priority();
        test_decode();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
